// File: rtl/cnt_step_monitor_pkg.sv
// Shared types and constants for the ripple-counter step monitor.
package cnt_step_monitor_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    // Post-reset cycles spent in INIT so the synchroniser holds a real sample.
    localparam logic [1:0] INIT_FLUSH = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cnt_step_monitor_if.sv
// Count bus between the ripple-counter side (master) and the monitor (slave).
interface cnt_step_monitor_if #(
    parameter int CW = 2,
    parameter int WW = 8
);
    logic [CW-1:0] cnt_in;
    logic          clr;
    logic [CW-1:0] cnt_q;
    logic          step;
    logic          wrap;
    logic [WW-1:0] wraps;
    logic          stall;
    logic          err;

    modport master (output cnt_in, output clr,
                    input cnt_q, input step, input wrap, input wraps, input stall, input err);
    modport slave  (input cnt_in, input clr,
                    output cnt_q, output step, output wrap, output wraps, output stall, output err);
endinterface

// File: rtl/cnt_step_monitor_sync2.sv
// Two-flop synchroniser bringing the asynchronous count into the clk domain.
module cnt_step_monitor_sync2 #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] d,
    output logic [CW-1:0] q
);
    logic [CW-1:0] s1_r;
    logic [CW-1:0] s2_r;

    // Synchroniser chain d -> s1 -> s2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_r <= {CW{1'b0}};
            s2_r <= {CW{1'b0}};
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;
endmodule

// File: rtl/cnt_step_monitor.sv
// Classifies each change of the synchronised ripple count as step, wrap or error,
// accumulates wraps and flags a stalled counter.
module cnt_step_monitor
    import cnt_step_monitor_pkg::*;
#(
    parameter int CW        = 2,
    parameter int WW        = 8,
    parameter int STALL_LIM = 16
) (
    input  logic                clk,
    input  logic                rst,
    cnt_step_monitor_if.slave   bus
);
    localparam logic [CW-1:0] ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] TOP   = {CW{1'b1}};
    localparam logic [WW-1:0] WMAX  = {WW{1'b1}};
    localparam logic [15:0]   LIM16 = 16'(STALL_LIM);

    logic [CW-1:0] s2_s;
    logic [CW-1:0] delta_s;
    logic [15:0]   idle_inc_s;
    logic          classify_s;
    logic          is_step_s;
    logic          is_wrap_s;
    logic          wrap_ev_s;
    logic          err_ev_s;

    state_t        state_r;
    logic [1:0]    init_cnt_r;
    logic [CW-1:0] prev_r;
    logic [15:0]   idle_r;
    logic          step_r;
    logic          wrap_r;
    logic [WW-1:0] wraps_r;
    logic          stall_r;
    logic          err_r;

    cnt_step_monitor_sync2 #(.CW(CW)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.cnt_in),
        .q   (s2_s)
    );

    // Delta classification of the newest synchronised sample against prev.
    always_comb begin
        delta_s    = s2_s - prev_r;
        idle_inc_s = sat_inc16(idle_r);
        classify_s = (state_r == ST_RUN) || (state_r == ST_STALL);
        is_step_s  = (delta_s == ONE);
        is_wrap_s  = is_step_s && (prev_r == TOP);
        if (classify_s) begin
            wrap_ev_s = is_wrap_s;
            err_ev_s  = (delta_s != ZERO) && !is_step_s;
        end else begin
            wrap_ev_s = 1'b0;
            err_ev_s  = 1'b0;
        end
    end

    // State machine, pulse outputs, stall detection and wrap/error accumulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_INIT;
            init_cnt_r <= 2'd0;
            prev_r     <= ZERO;
            idle_r     <= 16'd0;
            step_r     <= 1'b0;
            wrap_r     <= 1'b0;
            wraps_r    <= {WW{1'b0}};
            stall_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            step_r <= 1'b0;
            wrap_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r == INIT_FLUSH) begin
                        prev_r  <= s2_s;
                        idle_r  <= 16'd0;
                        state_r <= ST_RUN;
                    end else begin
                        init_cnt_r <= init_cnt_r + 2'd1;
                    end
                end
                ST_RUN, ST_STALL: begin
                    prev_r <= s2_s;
                    if (delta_s == ZERO) begin
                        // Once stalled the idle count is irrelevant until the next change.
                        if (state_r == ST_RUN) begin
                            idle_r <= idle_inc_s;
                            if (idle_inc_s >= LIM16) begin
                                state_r <= ST_STALL;
                                stall_r <= 1'b1;
                            end else begin
                                stall_r <= 1'b0;
                            end
                        end else begin
                            stall_r <= 1'b1;
                        end
                    end else begin
                        idle_r  <= 16'd0;
                        stall_r <= 1'b0;
                        state_r <= ST_RUN;
                        step_r  <= is_step_s;
                        wrap_r  <= is_wrap_s;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase

            if (bus.clr) begin
                wraps_r <= {WW{1'b0}};
                err_r   <= 1'b0;
            end else begin
                if (wrap_ev_s && (wraps_r != WMAX)) begin
                    wraps_r <= wraps_r + {{(WW-1){1'b0}}, 1'b1};
                end else begin
                    wraps_r <= wraps_r;
                end
                if (err_ev_s) begin
                    err_r <= 1'b1;
                end else begin
                    err_r <= err_r;
                end
            end
        end
    end

    assign bus.cnt_q = prev_r;
    assign bus.step  = step_r;
    assign bus.wrap  = wrap_r;
    assign bus.wraps = wraps_r;
    assign bus.stall = stall_r;
    assign bus.err   = err_r;
endmodule

// File: tb/tb_cnt_step_monitor.sv
// Bench for cnt_step_monitor (CW=2, WW=2, STALL_LIM=4) against a delay-queue reference model.
module tb_cnt_step_monitor;
    localparam int CW  = 2;
    localparam int WW  = 2;
    localparam int LIM = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cnt_step_monitor_if #(.CW(CW), .WW(WW)) bus ();

    cnt_step_monitor #(.CW(CW), .WW(WW), .STALL_LIM(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the monitor sees cnt_in two edges late, then applies the rules.
    logic [1:0] pipe [$];
    int         init_left;
    int         idle;
    logic [1:0] m_last;
    logic       m_step;
    logic       m_wrap;
    logic [1:0] m_wraps;
    logic       m_stall;
    logic       m_err;

    task automatic model_step(input logic [1:0] c, input logic cl, input logic r);
        logic [1:0] seen;
        logic [1:0] d;
        logic wev;
        logic eev;
        wev = 1'b0;
        eev = 1'b0;
        if (!r) begin
            pipe = '{2'b00, 2'b00};
            init_left = 3;
            idle = 0;
            m_last = 2'b00; m_step = 1'b0; m_wrap = 1'b0;
            m_wraps = 2'b00; m_stall = 1'b0; m_err = 1'b0;
            return;
        end
        seen = pipe.pop_front();
        pipe.push_back(c);
        m_step = 1'b0;
        m_wrap = 1'b0;
        if (init_left > 0) begin
            init_left--;
            if (init_left == 0) m_last = seen;
        end else begin
            d = seen - m_last;
            if (d == 2'd0) begin
                if (!m_stall) begin
                    idle++;
                    if (idle >= LIM) m_stall = 1'b1;
                end
            end else begin
                idle = 0;
                m_stall = 1'b0;
                if (d == 2'd1) begin
                    m_step = 1'b1;
                    if (m_last == 2'd3) begin
                        m_wrap = 1'b1;
                        wev = 1'b1;
                    end
                end else begin
                    eev = 1'b1;
                end
            end
            m_last = seen;
        end
        if (cl) begin
            m_wraps = 2'b00;
            m_err = 1'b0;
        end else begin
            if (wev && m_wraps != 2'd3) m_wraps = m_wraps + 2'd1;
            if (eev) m_err = 1'b1;
        end
    endtask

    function automatic logic [7:0] obs();
        return {bus.cnt_q, bus.step, bus.wrap, bus.wraps, bus.stall, bus.err};
    endfunction

    function automatic logic [7:0] expv();
        return {m_last, m_step, m_wrap, m_wraps, m_stall, m_err};
    endfunction

    task automatic tick(input logic [1:0] c, input logic cl, input logic r);
        bus.cnt_in = c;
        bus.clr    = cl;
        rst        = r;
        @(posedge clk);
        model_step(c, cl, r);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] c);
        tick(c, 1'b0, 1'b0);
        tick(c, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(c, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(2'b10, 1'b0, 1'b0);
            checks++;
            if (obs() !== 8'h00) begin
                failures++;
                $display("FAIL reset_outputs actual=%h expected=00", obs());
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick(2'b10, 1'b0, 1'b1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL init_model cycle=%0d actual=%h expected=%h", i, obs(), expv());
            end
        end
        checks++;
        if ({bus.cnt_q, bus.step, bus.wrap, bus.err} !== 5'b10000) begin
            failures++;
            $display("FAIL init_cnt_q actual=%b expected=10000", {bus.cnt_q, bus.step, bus.wrap, bus.err});
        end
    endtask

    task automatic test_stepping();
        logic [1:0] vals [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        int n_step;
        int n_wrap;
        logic exp_step;
        n_step = 0;
        n_wrap = 0;
        do_reset(2'd0);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                tick(vals[i], 1'b0, 1'b1);
                exp_step = (j == 2);
                checks++;
                if (bus.step !== exp_step || obs() !== expv()) begin
                    failures++;
                    $display("FAIL step_timing val=%0d j=%0d actual=%h expected=%h step_expected=%b",
                             vals[i], j, obs(), expv(), exp_step);
                end
                n_step += int'(bus.step);
                n_wrap += int'(bus.wrap);
            end
        end
        checks++;
        if (n_step != 4 || n_wrap != 1 || bus.wraps !== 2'd1 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL step_totals actual steps=%0d wraps_p=%0d wraps=%0d err=%b expected 4 1 1 0",
                     n_step, n_wrap, bus.wraps, bus.err);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] exp_w [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset(2'd0);
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 3; j++) tick(seq[i], 1'b0, 1'b1);
            end
            checks++;
            if (bus.wraps !== exp_w[w] || obs() !== expv()) begin
                failures++;
                $display("FAIL wraps_sat pass=%0d actual=%0d expected=%0d", w, bus.wraps, exp_w[w]);
            end
        end
    endtask

    task automatic test_skip_error();
        int n_step;
        n_step = 0;
        do_reset(2'd0);
        for (int j = 0; j < 4; j++) begin
            tick(2'd2, 1'b0, 1'b1);
            n_step += int'(bus.step);
        end
        checks++;
        if (bus.err !== 1'b1 || n_step != 0) begin
            failures++;
            $display("FAIL skip_err actual err=%b steps=%0d expected err=1 steps=0", bus.err, n_step);
        end
        for (int j = 0; j < 4; j++) tick(2'd3, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) tick(2'd0, 1'b0, 1'b1);
        checks++;
        if (bus.err !== 1'b1 || bus.wraps !== 2'd1) begin
            failures++;
            $display("FAIL err_sticky actual err=%b wraps=%0d expected err=1 wraps=1", bus.err, bus.wraps);
        end
        tick(2'd0, 1'b1, 1'b1);
        checks++;
        if (bus.err !== 1'b0 || bus.wraps !== 2'd0) begin
            failures++;
            $display("FAIL clr actual err=%b wraps=%0d expected err=0 wraps=0", bus.err, bus.wraps);
        end
    endtask

    task automatic test_stall();
        do_reset(2'd1);
        for (int j = 0; j < 6; j++) begin
            tick(2'd1, 1'b0, 1'b1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL stall_model j=%0d actual=%h expected=%h", j, obs(), expv());
            end
        end
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL stall_set actual=%b expected=1", bus.stall);
        end
        for (int j = 0; j < 3; j++) begin
            tick(2'd2, 1'b0, 1'b1);
            if (j == 1) begin
                checks++;
                if ({bus.stall, bus.step} !== 2'b10) begin
                    failures++;
                    $display("FAIL stall_hold actual=%b expected=10", {bus.stall, bus.step});
                end
            end
        end
        checks++;
        if ({bus.stall, bus.step} !== 2'b01) begin
            failures++;
            $display("FAIL stall_exit actual stall,step=%b expected=01", {bus.stall, bus.step});
        end
    endtask

    task automatic run_to_wrap_edge(input logic cl, input logic r);
        for (int v = 1; v < 4; v++) begin
            for (int j = 0; j < 3; j++) tick(2'(v), 1'b0, 1'b1);
        end
        tick(2'd0, 1'b0, 1'b1);
        tick(2'd0, 1'b0, 1'b1);
        tick(2'd0, cl, r);
    endtask

    task automatic test_priority();
        do_reset(2'd0);
        for (int w = 0; w < 3; w++) run_to_wrap_edge(1'b0, 1'b1);
        checks++;
        if (bus.wraps !== 2'd3) begin
            failures++;
            $display("FAIL prio_setup actual=%0d expected=3", bus.wraps);
        end
        run_to_wrap_edge(1'b1, 1'b1);
        checks++;
        if ({bus.wrap, bus.wraps} !== 3'b100) begin
            failures++;
            $display("FAIL clr_vs_wrap actual wrap,wraps=%b expected=100", {bus.wrap, bus.wraps});
        end
        run_to_wrap_edge(1'b0, 1'b0);
        checks++;
        if (obs() !== 8'h00) begin
            failures++;
            $display("FAIL rst_vs_wrap actual=%h expected=00", obs());
        end
        // A jump to 3 right after reset must be absorbed by INIT, not flagged.
        for (int j = 0; j < 4; j++) begin
            tick(2'd3, 1'b0, 1'b1);
            checks++;
            if (obs() !== expv() || bus.err !== 1'b0 || bus.step !== 1'b0) begin
                failures++;
                $display("FAIL rst_reinit j=%0d actual=%h expected=%h", j, obs(), expv());
            end
        end
        checks++;
        if (bus.cnt_q !== 2'd3) begin
            failures++;
            $display("FAIL reinit_load actual=%0d expected=3", bus.cnt_q);
        end
    endtask

    task automatic test_random();
        logic [1:0] cur;
        logic cl;
        logic r;
        int p;
        cur = 2'($urandom_range(3, 0));
        do_reset(cur);
        for (int i = 0; i < 600; i++) begin
            p = int'($urandom_range(99, 0));
            if (p < 30) cur = cur + 2'd1;
            else if (p < 36) cur = 2'($urandom_range(3, 0));
            cl = ($urandom_range(99, 0) < 3);
            r  = !($urandom_range(199, 0) < 2);
            tick(cur, cl, r);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random i=%0d actual=%h expected=%h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        bus.cnt_in = 2'b00;
        bus.clr = 1'b0;
        checks = 0;
        failures = 0;
        test_reset();
        test_stepping();
        test_saturation();
        test_skip_error();
        test_stall();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
